// File: rtl/regfile_np.sv
// Multi-port register file: one write port, two registered read ports with
// write-first bypass, per-entry valid bits and a sequenced bulk-clear sweep.
module regfile_np #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     wr_ack,
  input  logic [$clog2(DEPTH)-1:0] ra_addr,
  input  logic [$clog2(DEPTH)-1:0] rb_addr,
  output logic [WIDTH-1:0]         ra_data,
  output logic [WIDTH-1:0]         rb_data,
  output logic                     ra_valid,
  output logic                     rb_valid,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [WIDTH-1:0]    ra_data_q, ra_data_d;
  logic [WIDTH-1:0]    rb_data_q, rb_data_d;
  logic                ra_valid_q, ra_valid_d;
  logic                rb_valid_q, rb_valid_d;
  logic                wr_ack_q, wr_ack_d;
  logic                busy_q, busy_d;
  logic                wr_go;
  logic                byp_a, byp_b;

  // A clear request in the same cycle wins over a write.
  assign wr_go = (state_q == S_IDLE) && we && !clr_req;
  assign byp_a = wr_go && (waddr == ra_addr);
  assign byp_b = wr_go && (waddr == rb_addr);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    vld_d   = vld_q;
    unique case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end else if (we) begin
          mem_d[waddr] = wdata;
          vld_d[waddr] = 1'b1;
        end
      end
      S_CLEAR: begin
        mem_d[idx_q] = RESET_VAL;
        vld_d[idx_q] = 1'b0;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Read ports sample pre-edge contents, so an entry swept this cycle
  // still reads its old value.
  always_comb begin
    ra_data_d  = byp_a ? wdata : mem_q[ra_addr];
    rb_data_d  = byp_b ? wdata : mem_q[rb_addr];
    ra_valid_d = byp_a | vld_q[ra_addr];
    rb_valid_d = byp_b | vld_q[rb_addr];
    wr_ack_d   = wr_go;
    busy_d     = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
      vld_q      <= '0;
      ra_data_q  <= '0;
      rb_data_q  <= '0;
      ra_valid_q <= 1'b0;
      rb_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      vld_q      <= vld_d;
      ra_data_q  <= ra_data_d;
      rb_data_q  <= rb_data_d;
      ra_valid_q <= ra_valid_d;
      rb_valid_q <= rb_valid_d;
      wr_ack_q   <= wr_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign ra_data  = ra_data_q;
  assign rb_data  = rb_data_q;
  assign ra_valid = ra_valid_q;
  assign rb_valid = rb_valid_q;
  assign wr_ack   = wr_ack_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_np.sv
// Self-checking bench for regfile_np: directed scenarios plus randomized
// traffic checked against a cycle-level array model.
module tb_regfile_np;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 2;
  localparam logic [W-1:0] RV = 8'h00;

  logic          clk = 1'b0;
  logic          rst, we, clr_req;
  logic [AW-1:0] waddr, ra_addr, rb_addr;
  logic [W-1:0]  wdata;
  logic          wr_ack, ra_valid, rb_valid, busy;
  logic [W-1:0]  ra_data, rb_data;

  int n_pass = 0;
  int n_total = 0;

  logic [W-1:0] m_mem [D];
  logic         m_vld [D];
  int           sweep_left;
  int           sweep_pos;

  logic [W-1:0] exp_ra, exp_rb;
  logic         exp_rav, exp_rbv, exp_ack, exp_busy;

  always #5 clk = ~clk;

  regfile_np #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .wr_ack(wr_ack), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data),
    .ra_valid(ra_valid), .rb_valid(rb_valid),
    .clr_req(clr_req), .busy(busy)
  );

  // Advance one clock; model computes what the edge should produce.
  task automatic tick();
    logic acc;
    acc = !rst && (sweep_left == 0) && we && !clr_req;
    if (rst) begin
      exp_ra = '0; exp_rb = '0; exp_rav = 0; exp_rbv = 0; exp_ack = 0;
    end else begin
      exp_ra  = (acc && waddr == ra_addr) ? wdata : m_mem[ra_addr];
      exp_rb  = (acc && waddr == rb_addr) ? wdata : m_mem[rb_addr];
      exp_rav = (acc && waddr == ra_addr) ? 1'b1 : m_vld[ra_addr];
      exp_rbv = (acc && waddr == rb_addr) ? 1'b1 : m_vld[rb_addr];
      exp_ack = acc;
    end
    if (rst) begin
      for (int i = 0; i < D; i++) begin m_mem[i] = RV; m_vld[i] = 0; end
      sweep_left = 0;
    end else if (sweep_left > 0) begin
      m_mem[sweep_pos] = RV;
      m_vld[sweep_pos] = 0;
      sweep_pos++;
      sweep_left--;
    end else if (clr_req) begin
      sweep_left = D;
      sweep_pos  = 0;
    end else if (we) begin
      m_mem[waddr] = wdata;
      m_vld[waddr] = 1;
    end
    exp_busy = (sweep_left != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst = 0; we = 0; clr_req = 0;
  endtask

  task automatic wait_not_busy();
    int n;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    n_total++;
    if (busy) $display("FAIL wait_busy_timeout busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic fill(input logic [W-1:0] base);
    for (int i = 0; i < D; i++) begin
      we = 1; waddr = AW'(i); wdata = base + W'(i * 8'h11);
      tick();
    end
    we = 0;
  endtask

  task automatic test_reset();
    rst = 1; we = 0; clr_req = 0; waddr = 0; wdata = 0;
    ra_addr = 0; rb_addr = 0;
    tick(); tick();
    idle_in();
    n_total++;
    if ({ra_data, rb_data, ra_valid, rb_valid, wr_ack, busy} !== '0)
      $display("FAIL reset_outputs got=%h required 0",
               {ra_data, rb_data, ra_valid, rb_valid, wr_ack, busy});
    else n_pass++;
  endtask

  task automatic test_valid();
    ra_addr = 3; tick();
    n_total++;
    if (ra_data !== 8'h00 || ra_valid !== 1'b0)
      $display("FAIL valid_after_reset got=%h/%b required 00/0", ra_data, ra_valid);
    else n_pass++;
    we = 1; waddr = 3; wdata = 8'h77; ra_addr = 0; tick();
    we = 0; ra_addr = 3; tick();
    n_total++;
    if (ra_data !== 8'h77 || ra_valid !== 1'b1)
      $display("FAIL valid_after_write got=%h/%b required 77/1", ra_data, ra_valid);
    else n_pass++;
  endtask

  task automatic test_fill_read();
    logic [W-1:0] vals [4];
    int acks;
    vals[0] = 8'hA0; vals[1] = 8'hB1; vals[2] = 8'hC2; vals[3] = 8'hD3;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      we = 1; waddr = AW'(i); wdata = vals[i]; tick();
      if (wr_ack === 1'b1) acks++;
    end
    we = 0; ra_addr = 0; rb_addr = 1; tick();
    n_total++;
    if (acks != 4) $display("FAIL wr_ack_count got=%0d required 4", acks);
    else n_pass++;
    n_total++;
    if (ra_data !== 8'hA0 || rb_data !== 8'hB1 || !ra_valid || !rb_valid)
      $display("FAIL read_01 got=%h,%h,%b,%b required A0,B1,1,1",
               ra_data, rb_data, ra_valid, rb_valid);
    else n_pass++;
    n_total++;
    if (wr_ack !== 1'b0) $display("FAIL wr_ack_idle got=%b required 0", wr_ack);
    else n_pass++;
    ra_addr = 2; rb_addr = 3; tick();
    n_total++;
    if (ra_data !== 8'hC2 || rb_data !== 8'hD3 || !ra_valid || !rb_valid)
      $display("FAIL read_23 got=%h,%h,%b,%b required C2,D3,1,1",
               ra_data, rb_data, ra_valid, rb_valid);
    else n_pass++;
  endtask

  task automatic test_bypass();
    we = 1; waddr = 2; wdata = 8'h5A; ra_addr = 2; rb_addr = 2; tick();
    we = 0;
    n_total++;
    if (ra_data !== 8'h5A || rb_data !== 8'h5A || !ra_valid || !rb_valid
        || wr_ack !== 1'b1)
      $display("FAIL bypass got=%h,%h,%b,%b ack=%b required 5A,5A,1,1 ack=1",
               ra_data, rb_data, ra_valid, rb_valid, wr_ack);
    else n_pass++;
  endtask

  task automatic test_clear();
    int n;
    logic ack_seen;
    fill(8'h10);
    clr_req = 1; tick();
    clr_req = 0;
    n = 0; ack_seen = 0;
    for (int i = 0; i < 12 && busy; i++) begin
      n++;
      if (i == 0) begin we = 1; waddr = 0; wdata = 8'hFF; end
      else we = 0;
      tick();
      if (i == 0) ack_seen = wr_ack;
    end
    we = 0;
    n_total++;
    if (n != D) $display("FAIL busy_length got=%0d required %0d", n, D);
    else n_pass++;
    n_total++;
    if (ack_seen !== 1'b0) $display("FAIL write_during_busy ack=%b required 0", ack_seen);
    else n_pass++;
    for (int i = 0; i < D; i += 2) begin
      ra_addr = AW'(i); rb_addr = AW'(i + 1); tick();
      n_total++;
      if (ra_data !== RV || rb_data !== RV || ra_valid || rb_valid)
        $display("FAIL cleared_%0d got=%h,%h,%b,%b required 00,00,0,0",
                 i, ra_data, rb_data, ra_valid, rb_valid);
      else n_pass++;
    end
    // Write accepted on the first idle cycle after the sweep.
    we = 1; waddr = 1; wdata = 8'h42; tick(); we = 0;
    n_total++;
    if (wr_ack !== 1'b1) $display("FAIL write_after_clear ack=%b required 1", wr_ack);
    else n_pass++;
  endtask

  task automatic test_midsweep();
    fill(8'h03);
    clr_req = 1; ra_addr = 0; tick();
    clr_req = 0; ra_addr = 3; tick();
    n_total++;
    if (ra_data !== 8'h36 || ra_valid !== 1'b1)
      $display("FAIL midsweep_old got=%h/%b required 36/1", ra_data, ra_valid);
    else n_pass++;
    ra_addr = 1; rb_addr = 2; tick();
    n_total++;
    if (ra_data !== 8'h14 || rb_data !== 8'h25)
      $display("FAIL sweep_same_cycle got=%h,%h required 14,25", ra_data, rb_data);
    else n_pass++;
    wait_not_busy();
    ra_addr = 3; tick();
    n_total++;
    if (ra_data !== RV || ra_valid !== 1'b0)
      $display("FAIL after_sweep got=%h/%b required 00/0", ra_data, ra_valid);
    else n_pass++;
  endtask

  task automatic test_collision();
    int n;
    clr_req = 1; we = 1; waddr = 1; wdata = 8'h99; tick();
    we = 0;
    n_total++;
    if (wr_ack !== 1'b0 || busy !== 1'b1)
      $display("FAIL clr_we_collision ack=%b busy=%b required 0,1", wr_ack, busy);
    else n_pass++;
    n = 0;
    for (int i = 0; i < 12 && busy; i++) begin
      clr_req = (i < 3);
      n++;
      tick();
    end
    clr_req = 0;
    n_total++;
    if (n != D) $display("FAIL clr_ignored_busy got=%0d required %0d", n, D);
    else n_pass++;
  endtask

  task automatic test_reset_midsweep();
    fill(8'h20);
    clr_req = 1; tick();
    clr_req = 0; tick();
    rst = 1; tick();
    rst = 0;
    n_total++;
    if ({ra_data, rb_data, ra_valid, rb_valid, wr_ack, busy} !== '0)
      $display("FAIL reset_midsweep got=%h required 0",
               {ra_data, rb_data, ra_valid, rb_valid, wr_ack, busy});
    else n_pass++;
    we = 1; waddr = 2; wdata = 8'h3C; ra_addr = 2; rb_addr = 3; tick();
    we = 0;
    n_total++;
    if (wr_ack !== 1'b1 || ra_data !== 8'h3C || rb_valid !== 1'b0)
      $display("FAIL write_after_rst ack=%b ra=%h rbv=%b required 1,3C,0",
               wr_ack, ra_data, rb_valid);
    else n_pass++;
    ra_addr = 0; rb_addr = 1; tick();
    n_total++;
    if (ra_data !== RV || rb_data !== RV || ra_valid || rb_valid)
      $display("FAIL rst_cleared got=%h,%h,%b,%b required 00,00,0,0",
               ra_data, rb_data, ra_valid, rb_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 99) < 2);
      clr_req = ($urandom_range(0, 99) < 6);
      we      = $urandom_range(0, 1);
      waddr   = AW'($urandom_range(0, D - 1));
      ra_addr = AW'($urandom_range(0, D - 1));
      rb_addr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, D - 1));
      wdata   = W'($urandom);
      tick();
      n_total++;
      if ({ra_data, rb_data, ra_valid, rb_valid, wr_ack, busy} !==
          {exp_ra, exp_rb, exp_rav, exp_rbv, exp_ack, exp_busy})
        $display("FAIL random_c%0d got=%h,%h,%b,%b,%b,%b required %h,%h,%b,%b,%b,%b",
                 c, ra_data, rb_data, ra_valid, rb_valid, wr_ack, busy,
                 exp_ra, exp_rb, exp_rav, exp_rbv, exp_ack, exp_busy);
      else n_pass++;
    end
    idle_in();
  endtask

  initial begin
    sweep_left = 0;
    sweep_pos  = 0;
    for (int i = 0; i < D; i++) begin m_mem[i] = RV; m_vld[i] = 0; end
    test_reset();
    test_valid();
    test_fill_read();
    test_bypass();
    test_clear();
    test_midsweep();
    test_collision();
    test_reset_midsweep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
